// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and command-byte field positions for the SPI register controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_DISCARD
  } state_t;

  localparam int CMD_RD_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

endpackage

// File: rtl/spi_reg_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Parses SPI byte frames (command + burst beats) into accesses of the configuration
// register bank, and supplies read data for the MISO shifter.
//
// state      | meaning
// ST_IDLE    | chip-select released, waiting for assertion
// ST_CMD     | waiting for the command byte
// ST_WRITE   | each byte writes reg[addr], addr auto-increments
// ST_READ    | each dummy byte advances addr and loads tx_data
// ST_DISCARD | frame aborted (bad address or timeout), ignore until release
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter int         ADDR_W      = $clog2(NUM_REGS),
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter int         TIMEOUT_CYC = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data,
  output logic [7:0]            tx_data,
  output logic                  tx_load,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                CNT_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);

  logic              cs_s;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        bank_q [NUM_REGS];
  logic              wr_strobe_q, tx_load_q, frame_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q, tx_data_q;

  logic [ADDR_W-1:0] addr_inc_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic              cmd_bad_d;
  logic              counting_d;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cs),
    .q_o (cs_s)
  );

  // Full 7-bit command address is range-checked before truncation to ADDR_W.
  assign cmd_bad_d  = {1'b0, rx_data[CMD_ADDR_MSB:0]} >= NUM_REGS_B;
  assign cmd_addr_d = rx_data[ADDR_W-1:0];
  assign addr_inc_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
  assign counting_d = (state_q == ST_CMD) || (state_q == ST_WRITE) || (state_q == ST_READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wr_strobe_q <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= RESET_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;

      if (counting_d && !rx_valid) begin
        if (cnt_q == TO_LAST) begin
          cnt_q       <= '0;
          frame_err_q <= 1'b1;
          state_q     <= ST_DISCARD;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end

      case (state_q)
        ST_IDLE: if (!cs_s) state_q <= ST_CMD;
        ST_CMD: if (rx_valid) begin
          addr_q <= cmd_addr_d;
          if (cmd_bad_d) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_DISCARD;
          end else if (rx_data[CMD_RD_BIT]) begin
            tx_data_q <= bank_q[cmd_addr_d];
            tx_load_q <= 1'b1;
            state_q   <= ST_READ;
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: if (rx_valid) begin
          bank_q[addr_q] <= rx_data;
          wr_strobe_q    <= 1'b1;
          wr_addr_q      <= addr_q;
          wr_data_q      <= rx_data;
          addr_q         <= addr_inc_d;
        end
        ST_READ: if (rx_valid) begin
          addr_q    <= addr_inc_d;
          tx_data_q <= bank_q[addr_inc_d];
          tx_load_q <= 1'b1;
        end
        default: ;
      endcase

      // Release overrides any transition above; the same-cycle byte is still processed.
      if (state_q != ST_IDLE && cs_s) state_q <= ST_IDLE;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_q[8*k +: 8] = bank_q[k];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: frame parsing, burst wrap, reads, aborts and reset.
module tb_spi_reg_ctrl;

  localparam int NR = 16;
  localparam int AW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [NR*8-1:0] reg_q;
  logic          wr_strobe, tx_load, frame_err, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, tx_data;

  spi_reg_ctrl #(.NUM_REGS(NR), .RESET_VAL(8'h00), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx_data(tx_data), .tx_load(tx_load), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int fe_cnt = 0;
  logic [AW-1:0] last_wa;
  logic [7:0]    last_wd;
  logic [7:0]    ld_log[$];
  logic [7:0]    model [NR];

  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (tx_load) ld_log.push_back(tx_data);
    if (frame_err) fe_cnt++;
  end

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  // All drive tasks start and end #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic cs_assert();
    cs = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic cs_release(output int n);
    cs = 1'b1;
    n = 0;
    while (busy && n < 10) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    n_cmp++;
    if (reg_q !== model_flat()) begin n_err++; $display("FAIL reset_regs got=%h exp=%h", reg_q, model_flat()); end
    n_cmp++;
    if ({wr_strobe, tx_load, frame_err, busy} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=0000", {wr_strobe, tx_load, frame_err, busy});
    end
    n_cmp++;
    if ({wr_addr, wr_data, tx_data} !== '0) begin
      n_err++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", wr_addr, wr_data, tx_data);
    end
  endtask

  task automatic test_single_write();
    int w0, n;
    w0 = wr_cnt;
    cs_assert();
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_on got=%b exp=1", busy); end
    send_byte(8'h03, 2);
    send_byte(8'h5A, 2);
    model[3] = 8'h5A;
    n_cmp++;
    if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL sw_strobes got=%0d exp=1", wr_cnt - w0); end
    n_cmp++;
    if (last_wa !== 4'd3 || last_wd !== 8'h5A) begin
      n_err++; $display("FAIL sw_addr_data got=%0d/%h exp=3/5a", last_wa, last_wd);
    end
    n_cmp++;
    if (reg_q !== model_flat()) begin n_err++; $display("FAIL sw_regs got=%h exp=%h", reg_q, model_flat()); end
    cs_release(n);
    n_cmp++;
    if (n !== 3) begin n_err++; $display("FAIL sw_busy_fall got=%0d exp=3", n); end
  endtask

  task automatic test_burst_wrap();
    int w0, n;
    w0 = wr_cnt;
    cs_assert();
    send_byte(8'h0E, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    send_byte(8'h33, 1);
    model[14] = 8'h11; model[15] = 8'h22; model[0] = 8'h33;
    n_cmp++;
    if (wr_cnt - w0 !== 3) begin n_err++; $display("FAIL bw_strobes got=%0d exp=3", wr_cnt - w0); end
    n_cmp++;
    if (last_wa !== 4'd0 || last_wd !== 8'h33) begin
      n_err++; $display("FAIL bw_last got=%0d/%h exp=0/33", last_wa, last_wd);
    end
    n_cmp++;
    if (reg_q !== model_flat()) begin n_err++; $display("FAIL bw_regs got=%h exp=%h", reg_q, model_flat()); end
    cs_release(n);
  endtask

  task automatic test_burst_read();
    int w0, n;
    logic [7:0] exp_ld [3];
    exp_ld[0] = 8'h22; exp_ld[1] = 8'h33; exp_ld[2] = 8'h00;
    w0 = wr_cnt;
    ld_log.delete();
    cs_assert();
    send_byte(8'h8F, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hFF, 1);
    n_cmp++;
    if (ld_log.size() !== 3) begin n_err++; $display("FAIL br_loads got=%0d exp=3", ld_log.size()); end
    for (int i = 0; i < 3 && i < ld_log.size(); i++) begin
      n_cmp++;
      if (ld_log[i] !== exp_ld[i]) begin
        n_err++; $display("FAIL br_data%0d got=%h exp=%h", i, ld_log[i], exp_ld[i]);
      end
    end
    n_cmp++;
    if (wr_cnt !== w0 || reg_q !== model_flat()) begin
      n_err++; $display("FAIL br_no_write got=%0d strobes exp=0", wr_cnt - w0);
    end
    cs_release(n);
  endtask

  task automatic test_bad_addr();
    int w0, f0, n;
    w0 = wr_cnt;
    f0 = fe_cnt;
    cs_assert();
    send_byte(8'h20, 0);
    n_cmp++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL ba_err_timing got=%b exp=1", frame_err); end
    @(posedge clk); #1;
    send_byte(8'h77, 5);
    n_cmp++;
    if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ba_err_count got=%0d exp=1", fe_cnt - f0); end
    n_cmp++;
    if (wr_cnt !== w0 || reg_q !== model_flat()) begin
      n_err++; $display("FAIL ba_no_write got=%0d strobes exp=0", wr_cnt - w0);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL ba_busy_hold got=%b exp=1", busy); end
    cs_release(n);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL ba_busy_rel got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int w0, n, hit;
    w0 = wr_cnt;
    cs_assert();
    send_byte(8'h02, 0);
    hit = -1;
    for (int c = 1; c <= 2 * TO; c++) begin
      @(posedge clk); #1;
      if (frame_err) begin hit = c; break; end
    end
    n_cmp++;
    if (hit !== TO) begin n_err++; $display("FAIL to_cycle got=%0d exp=%0d", hit, TO); end
    send_byte(8'h44, 2);
    n_cmp++;
    if (wr_cnt !== w0 || reg_q !== model_flat()) begin
      n_err++; $display("FAIL to_no_write got=%0d strobes reg2=%h exp=0/00", wr_cnt - w0, reg_q[16 +: 8]);
    end
    cs_release(n);
  endtask

  task automatic test_cmd_only();
    int w0, n;
    w0 = wr_cnt;
    cs_assert();
    send_byte(8'h05, 2);
    cs_release(n);
    n_cmp++;
    if (wr_cnt !== w0 || reg_q !== model_flat() || n !== 3) begin
      n_err++; $display("FAIL cmd_only got=%0d strobes fall=%0d exp=0/3", wr_cnt - w0, n);
    end
  endtask

  task automatic test_reset_mid();
    int w0, n;
    cs_assert();
    send_byte(8'h05, 2);
    send_byte(8'hA1, 2);
    send_byte(8'hA2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    n_cmp++;
    if (reg_q !== model_flat()) begin n_err++; $display("FAIL rm_regs got=%h exp=%h", reg_q, model_flat()); end
    n_cmp++;
    if ({wr_strobe, tx_load, frame_err, busy} !== 4'b0000 || {wr_addr, wr_data, tx_data} !== '0) begin
      n_err++; $display("FAIL rm_outputs got=%b %h/%h/%h exp=0000 0/0/0",
                        {wr_strobe, tx_load, frame_err, busy}, wr_addr, wr_data, tx_data);
    end
    cs_release(n);
    w0 = wr_cnt;
    cs_assert();
    send_byte(8'h01, 1);
    send_byte(8'h9C, 1);
    model[1] = 8'h9C;
    n_cmp++;
    if (wr_cnt - w0 !== 1 || last_wa !== 4'd1 || last_wd !== 8'h9C) begin
      n_err++; $display("FAIL rm_next_frame got=%0d strobes %0d/%h exp=1 1/9c", wr_cnt - w0, last_wa, last_wd);
    end
    n_cmp++;
    if (reg_q !== model_flat()) begin n_err++; $display("FAIL rm_next_regs got=%h exp=%h", reg_q, model_flat()); end
    cs_release(n);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_burst_read();
    test_bad_addr();
    test_timeout();
    test_cmd_only();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller behind spi_slave. It consumes the received byte stream (data_out/data_valid) plus chip-select and parses frames into register-bank accesses.
- Frame format: byte0 = command, where bit7 = R/nW (1 = read) and bits6:0 = start address. Each following byte is one burst beat with address auto-increment.
- Owns the configuration register bank used by the rest of the FPGA. It also feeds read data to a future MISO shifter via tx_data/tx_load.

Parameters:
- NUM_REGS, 16, number of 8-bit registers (2..128).
- ADDR_W, $clog2(NUM_REGS), register index width.
- RESET_VAL, 8'h00, reset value of every register.
- TIMEOUT_CYC, 25000, clk cycles with CS asserted and no byte before abort (1 ms at 25 MHz).

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- cs  in  1  raw SPI chip-select pin, active-low, asynchronous to clk
- rx_data  in  8  byte from spi_slave data_out
- rx_valid  in  1  one-cycle pulse from spi_slave data_valid
- reg_q  out  NUM_REGS*8  flattened register bank; reg k = reg_q[8k+7:8k]
- wr_strobe  out  1  one-cycle pulse per register write
- wr_addr  out  ADDR_W  address of current/last write
- wr_data  out  8  data of current/last write
- tx_data  out  8  read data for MISO shifter
- tx_load  out  1  one-cycle pulse, tx_data valid
- frame_err  out  1  one-cycle pulse on bad address or timeout
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All registers go to RESET_VAL; the FSM goes to IDLE.
  - wr_strobe, tx_load and frame_err go to 0. wr_addr, wr_data and tx_data go to 0. busy goes to 0.
  - The timeout counter goes to 0. The CS synchronizer flops go to 1 (deasserted).
  - Reset mid-frame discards the frame, and no write completes in that cycle.
- CS path:
  - cs passes through a 2-FF synchronizer, giving cs_s.
  - An assertion event is cs_s 1->0; a release event is cs_s 0->1.
  - rx_valid is already in the clk domain and is used unsynchronized.
- FSM states: IDLE, CMD, WRITE, READ, DISCARD.
- IDLE:
  - Waits for cs_s=0, then goes to CMD.
  - rx_valid in IDLE is ignored.
- CMD:
  - On rx_valid, latch the address: addr = rx_data[6:0].
  - If addr >= NUM_REGS: pulse frame_err the next cycle and go to DISCARD.
  - Else, if bit7=0, go to WRITE.
  - Else (bit7=1), go to READ: tx_data <= reg[addr] and tx_load pulses 1 cycle after the command byte's rx_valid.
- WRITE:
  - Each rx_valid writes reg[addr] <= rx_data.
  - wr_strobe, wr_addr and wr_data are registered, so they are visible 1 cycle after rx_valid; reg_q updates on the same edge.
  - Then addr increments, wrapping from NUM_REGS-1 to 0.
- READ:
  - Each rx_valid (dummy byte) increments addr, with the same wrap as WRITE.
  - Then tx_data <= reg[new addr] and tx_load pulses, 1 cycle after rx_valid.
  - Received data is ignored.
- DISCARD:
  - All bytes are ignored until release.
- Release (cs_s=1) in any non-IDLE state returns the FSM to IDLE next cycle.
  - A write with no data byte (command only) is legal and has no effect.
- Simultaneous release and rx_valid: the byte is processed normally (write or load), then the FSM goes to IDLE.
- Timeout:
  - The counter increments each cycle in CMD/WRITE/READ with no rx_valid, and clears on rx_valid or in IDLE/DISCARD.
  - When it reaches TIMEOUT_CYC-1: pulse frame_err and go to DISCARD.
  - rx_valid in the same cycle wins: the byte is processed and the counter clears.
- Read-during-write: a read returns register contents as of the cycle of the load. A write to the same register on the same edge is not forwarded.
- Arithmetic: addr is ADDR_W bits; wrap is explicit compare-to-(NUM_REGS-1), so non-power-of-2 NUM_REGS works. Command addr bits above ADDR_W are checked by the >= compare, not truncated.

Decomposition:
- Package spi_reg_pkg holds:
  - the state enum typedef;
  - the constant CMD_RD_BIT=7;
  - the constant CMD_ADDR_MSB=6.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer with a reset-value parameter, instantiated for cs.
- The register bank and FSM stay in spi_reg_ctrl.

Test Plan:
- Single write: cs low, bytes 0x03, 0x5A.
  - Expect: wr_strobe once with wr_addr=3, wr_data=0x5A; reg3=0x5A; all others 0x00; busy falls 3 cycles after cs high.
- Burst write with wrap (NUM_REGS=16): bytes 0x0E, 0x11, 0x22, 0x33.
  - Expect: reg14=0x11, reg15=0x22, reg0=0x33; 3 wr_strobe pulses.
- Burst read: after the writes above, bytes 0x8F, 0xFF, 0xFF.
  - Expect: tx_load x3 with tx_data 0x22, 0x33, then reg1=0x00.
- Bad address: byte 0x20 (addr 32 >= 16), then 0x77.
  - Expect: frame_err pulse; no wr_strobe; no register changes; busy stays high until cs high.
- Timeout (TIMEOUT_CYC=100 for sim): cs low, byte 0x02, then idle for 100 cycles.
  - Expect: frame_err at cycle 100; a later 0x44 byte is not written; reg2 unchanged.
- Reset mid-burst: rst pulse 1 cycle after the rx_valid of data byte 2 of a write.
  - Expect: all regs = RESET_VAL; all outputs 0; FSM in IDLE. The next frame (after cs high/low) works normally.
